// File: rtl/digit_entry_ctrl.sv
// Front-panel digit entry: sync/debounce three active-low keys and edit two 4-bit digits.
// Optional compile-time macro AUTO_REPEAT_EN adds hold-to-repeat on INC/DEC.
module digit_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_DIGIT       = 15,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       KEY_INC,
    input  logic       KEY_DEC,
    input  logic       KEY_SEL,
    output logic [3:0] a0,
    output logic [3:0] a1,
    output logic       sel,
    output logic       changed
);

    localparam int unsigned NUM_KEYS = 3;
    localparam int unsigned K_INC    = 0;
    localparam int unsigned K_DEC    = 1;
    localparam int unsigned K_SEL    = 2;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      DIGIT_MAX = 4'(MAX_DIGIT);

    // Reject parameter sets the datapath cannot represent.
    if (DEBOUNCE_CYCLES < 2 || MAX_DIGIT < 1 || MAX_DIGIT > 15 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("digit_entry_ctrl: illegal parameter value");
    end

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] sync_s1;
    logic [NUM_KEYS-1:0] sync_s2;
    logic [NUM_KEYS-1:0] synced;
    logic [NUM_KEYS-1:0] deb;
    logic [NUM_KEYS-1:0] deb_q;
    logic [NUM_KEYS-1:0] press_evt;
    logic [NUM_KEYS-1:0] evt_d;
    logic [NUM_KEYS-1:0] evt_q;
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];

    assign key_raw = {KEY_SEL, KEY_DEC, KEY_INC};

    // Two-flop synchroniser; reset value is the released (high) key level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1 <= '1;
            sync_s2 <= '1;
        end else begin
            sync_s1 <= key_raw;
            sync_s2 <= sync_s1;
        end
    end

    assign synced = ~sync_s2;

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (synced[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= synced[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press_evt = deb & ~deb_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt [2];
    logic [1:0]       rep_phase;
    logic [1:0]       rep_fire;

    // A count of zero means idle; phase 0 waits REPEAT_DELAY, phase 1 waits REPEAT_PERIOD.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = deb[i] && (rep_cnt[i] != '0) &&
                          (rep_cnt[i] == (rep_phase[i] ? REP_W'(REPEAT_PERIOD)
                                                       : REP_W'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_phase <= '0;
            for (int i = 0; i < 2; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!deb[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (press_evt[i]) begin
                    rep_cnt[i]   <= REP_W'(1);
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= REP_W'(1);
                    rep_phase[i] <= 1'b1;
                end else if (rep_cnt[i] != '0) begin
                    rep_cnt[i]   <= rep_cnt[i] + REP_W'(1);
                end
            end
        end
    end

    assign evt_d = press_evt | {1'b0, rep_fire};
`else
    assign evt_d = press_evt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '0;
            evt_q <= '0;
        end else begin
            deb_q <= deb;
            evt_q <= evt_d;
        end
    end

    logic [3:0] cur_digit;
    logic [3:0] new_digit;
    logic [3:0] a0_d;
    logic [3:0] a1_d;
    logic       sel_d;
    logic       changed_d;

    // Arithmetic acts on the current selection; a simultaneous SEL toggles afterwards.
    always_comb begin
        cur_digit = sel ? a1 : a0;
        new_digit = cur_digit;
        a0_d      = a0;
        a1_d      = a1;
        sel_d     = sel;
        if (evt_q[K_INC] && !evt_q[K_DEC]) begin
            new_digit = (cur_digit >= DIGIT_MAX) ? 4'd0 : cur_digit + 4'd1;
        end else if (evt_q[K_DEC] && !evt_q[K_INC]) begin
            new_digit = (cur_digit == 4'd0) ? DIGIT_MAX : cur_digit - 4'd1;
        end
        if (sel) begin
            a1_d = new_digit;
        end else begin
            a0_d = new_digit;
        end
        if (evt_q[K_SEL]) begin
            sel_d = ~sel;
        end
        changed_d = (a0_d != a0) || (a1_d != a1) || (sel_d != sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a0      <= 4'd0;
            a1      <= 4'd0;
            sel     <= 1'b0;
            changed <= 1'b0;
        end else begin
            a0      <= a0_d;
            a1      <= a1_d;
            sel     <= sel_d;
            changed <= changed_d;
        end
    end

endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
- Front-panel input controller: turns the push-buttons into the two 4-bit digit values a0/a1 that the seven-segment display path renders on HEX0/HEX2.
- Synchronises and debounces three active-low KEY inputs, edge-detects presses, and edits the selected digit with up/down wrap-around.
- Sits between the board KEY pins and the display block; the display block consumes the outputs directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synced samples required before a debounced level changes (10 ms at 50 MHz); must be >= 2.
- MAX_DIGIT, 15, largest digit value before wrap (9 = decimal entry, 15 = hex entry); range 1..15.
- REPEAT_DELAY, 25000000, cycles a held INC/DEC must stay pressed before the first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous reset, active-high.
- KEY_INC  input  1  increment button, active-low, asynchronous to clk.
- KEY_DEC  input  1  decrement button, active-low, asynchronous to clk.
- KEY_SEL  input  1  select-toggle button, active-low, asynchronous to clk.
- a0  output  4  digit 0 value, registered.
- a1  output  4  digit 1 value, registered.
- sel  output  1  selected digit: 0 = a0, 1 = a1.
- changed  output  1  one-cycle pulse, high in the cycle a0, a1 or sel takes a new value.

Behaviour:
- Reset (reset=1 at a rising edge): a0=0, a1=0, sel=0, changed=0. All synchroniser flops = 1 (released), debounced levels = released, debounce counters = 0, repeat counters = 0. Reset overrides every event in the same cycle.
- Synchroniser: each KEY passes through 2 flops. The synced level is the inverted second-stage output (1 = pressed).
- Debounce, per button:
  - Counter clears whenever synced level == debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Press event: debounced level goes released -> pressed. Release produces no event.
- Latency: a clean press stable from rising edge N updates the outputs at edge N+DEBOUNCE_CYCLES+3. changed is high for exactly that one cycle.
- Actions, taking effect the cycle after the event:
  - INC: selected digit +1; MAX_DIGIT -> 0.
  - DEC: selected digit -1; 0 -> MAX_DIGIT.
  - SEL: sel toggles; the non-selected digit is untouched.
- Simultaneous events in the same cycle:
  - INC and DEC together: digits unchanged.
  - INC or DEC together with SEL: arithmetic applies to the old selection, then sel toggles.
  - changed pulses once.
- changed is asserted only if at least one output value actually differs (e.g. INC+DEC alone gives no pulse).
- A button held through reset deassertion registers one press DEBOUNCE_CYCLES+3 cycles after reset falls.
- Reset asserted mid-debounce discards the partial count.
- If MAX_DIGIT < 15, outputs are never above MAX_DIGIT.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - While INC (or DEC) stays debounced-pressed, an extra event of that type is generated REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles until release.
  - Each repeat pulses changed and obeys the wrap rules. Release or reset clears the repeat counter.
  - SEL never repeats.
- Undefined: exactly one event per press regardless of hold time. REPEAT_DELAY and REPEAT_PERIOD are ignored, and no repeat counters are synthesised.

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGIT=15, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset held 3 cycles with all KEY=1 -> a0=0, a1=0, sel=0, changed=0. Then idle 50 cycles -> no change.
- KEY_INC low from edge N for 10 cycles, then high -> a0=1 and changed=1 at edge N+7 only. Repeat 15 more presses -> a0 wraps to 0 on the 16th.
- KEY_DEC 3-cycle low glitch -> no change. Then a clean 10-cycle press from a0=0 -> a0=15, a1=0.
- KEY_SEL press, then KEY_INC press -> sel=1, a1=1, a0 unchanged. KEY_INC and KEY_DEC low on the same edge -> no change, no changed pulse.
- KEY_INC held low through reset deassertion -> one increment 7 cycles after reset falls, none after.
- AUTO_REPEAT_EN defined, KEY_INC held 60 cycles from a0=0 -> events at press, +20, +28, +36, +44, +52. Final a0=6.
